// File: rtl/stepper_cmd_sched_if.sv
// rtl/stepper_cmd_sched_if.sv - CPU IO-window bus between memory stage and stepper command scheduler
//
// Purpose: bundles the CPU-side load/store signals of the IO window.
// Signals:
//   io_we     store to IO space this cycle
//   io_re     load from IO space this cycle
//   mem_addr  CPU byte address
//   data_in   store data
//   data_out  load data (registered in the scheduler)
//   cmd_full  command FIFO full (registered in the scheduler)
// Modports: master = CPU side, slave = scheduler side.

interface stepper_cmd_sched_if;
  logic        io_we;
  logic        io_re;
  logic [31:0] mem_addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        cmd_full;

  modport master (
    output io_we, io_re, mem_addr, data_in,
    input  data_out, cmd_full
  );

  modport slave (
    input  io_we, io_re, mem_addr, data_in,
    output data_out, cmd_full
  );
endinterface

// File: rtl/stepper_cmd_sched.sv
// rtl/stepper_cmd_sched.sv - queues CPU motion commands and issues them to the stepper one at a time
//
// Purpose: stores to the IO window push 32-bit motion commands into a FIFO;
// an FSM issues each command to the stepper, waits for busy to rise and fall,
// then issues the next. Loads return scheduler status or raw stepper status.
// Registers (selected by mem_addr[3:2] when mem_addr[IO_SEL_BIT]=1):
//   0 W: push command   R: {16'b0, count, 3'b0, paused, overflow, full, empty, engine_busy}
//   1 W: bit0 flush, bit1 pause (level), bit2 clear overflow   R: 0
//   2 R: step_status    3 R: 0
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   bus             CPU IO-window bus (slave modport)
//   step_data       command word to stepper, held until the next issue
//   step_new_data   one-cycle issue strobe
//   step_status     stepper status, bit0 = busy
// Build option: STEPPER_SCHED_TIMEOUT_EN enables the ACK_TIMEOUT exit from WAIT_BUSY.

module stepper_cmd_sched #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int IO_SEL_BIT  = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  stepper_cmd_sched_if.slave   bus,
  output logic [31:0]          step_data,
  output logic                 step_new_data,
  input  logic [31:0]          step_status
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state, state_next;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic            overflow, paused;
  logic            timed_out;
  logic [31:0]     rd_val, status;

  logic       sel, wr_fifo, wr_ctrl, rd_sel;
  logic [1:0] reg_idx;
  logic       empty, full, push, issue, flush, engine_busy;
  logic       unused_addr_bits;

  assign sel     = bus.mem_addr[IO_SEL_BIT];
  assign reg_idx = bus.mem_addr[3:2];
  assign wr_fifo = sel && bus.io_we && (reg_idx == 2'd0);
  assign wr_ctrl = sel && bus.io_we && (reg_idx == 2'd1);
  assign rd_sel  = sel && bus.io_re;
  assign unused_addr_bits = ^bus.mem_addr;

  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  // Acceptance looks only at the count at the start of the cycle, so a
  // push into a full FIFO is rejected even if ISSUE pops this cycle.
  assign push        = wr_fifo && !full;
  // A flush landing in the IDLE->ISSUE cycle can leave ISSUE with nothing
  // to pop; that ISSUE is then skipped instead of sending a stale word.
  assign issue       = (state == ISSUE) && !empty;
  assign flush       = wr_ctrl && bus.data_in[0];
  assign engine_busy = (state != IDLE);

  assign status = {16'b0, 8'(count), 3'b0, paused, overflow, full, empty, engine_busy};

`ifdef STEPPER_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts cycles spent in WAIT_BUSY; cleared in every other state.
  always_ff @(posedge clk) begin
    if (reset || state != WAIT_BUSY) tmo_cnt <= '0;
    else                             tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timed_out = (state == WAIT_BUSY) && (tmo_cnt == TW'(ACK_TIMEOUT - 1));
`else
  // Never true: without the timeout, WAIT_BUSY waits for busy indefinitely.
  assign timed_out = (ACK_TIMEOUT < 0);
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!empty && !paused && !step_status[0]) state_next = ISSUE;
      ISSUE:     state_next = issue ? WAIT_BUSY : IDLE;
      WAIT_BUSY: begin
        if (step_status[0])  state_next = WAIT_DONE;
        else if (timed_out)  state_next = IDLE;
      end
      WAIT_DONE: if (!step_status[0]) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (flush) count_next = '0;
    else       count_next = count + CW'(push) - CW'(issue);
  end

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      2'd0:    rd_val = status;
      2'd2:    rd_val = step_status;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      paused        <= 1'b0;
      step_data     <= '0;
      step_new_data <= 1'b0;
      bus.data_out  <= '0;
      bus.cmd_full  <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      bus.cmd_full  <= (count_next == FULL_CNT);
      step_new_data <= issue;
      if (issue) step_data <= mem[rd_ptr];
      // Flush drops queued entries only; an in-flight move carries on.
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (issue) rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_fifo && full)                 overflow <= 1'b1;
      else if (wr_ctrl && bus.data_in[2])  overflow <= 1'b0;
      if (wr_ctrl) paused <= bus.data_in[1];
      if (rd_sel)  bus.data_out <= rd_val;
    end
  end

endmodule

// File: tb/tb_stepper_cmd_sched.sv
// tb/tb_stepper_cmd_sched.sv - self-checking bench for stepper_cmd_sched

module tb_stepper_cmd_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] step_data;
  logic        step_new_data;
  logic [31:0] step_status;

  always #5 clk = ~clk;

  stepper_cmd_sched_if bus ();

  stepper_cmd_sched #(.DEPTH(4), .ACK_TIMEOUT(16), .IO_SEL_BIT(12)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .step_data     (step_data),
    .step_new_data (step_new_data),
    .step_status   (step_status)
  );

  // Stepper model: busy rises busy_delay cycles after the strobe cycle and
  // stays high for busy_len cycles.
  int          cyc = 0;
  int          strobe_cyc = 0;
  int          busy_delay = 2;
  int          busy_len = 10;
  logic        armed = 1'b0;
  logic        never_busy = 1'b0;
  logic [30:0] status_hi = 31'h2A5B3C4D;
  logic        model_busy;
  logic [31:0] issued[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (step_new_data) begin
      issued.push_back(step_data);
      strobe_cyc <= cyc;
      armed      <= 1'b1;
    end
  end

  assign model_busy = armed && !never_busy && (cyc - strobe_cyc >= busy_delay) &&
                      (cyc - strobe_cyc < busy_delay + busy_len);
  assign step_status = {status_hi, model_busy};

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_full;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_cycle(input logic we, input logic re, input logic [31:0] addr,
                           input logic [31:0] wdata);
    bus.io_we    = we;
    bus.io_re    = re;
    bus.mem_addr = addr;
    bus.data_in  = wdata;
    @(negedge clk);
    bus.io_we = 1'b0;
    bus.io_re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    bus_cycle(1'b1, 1'b0, addr, wdata);
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus_cycle(1'b0, 1'b1, addr, 32'h0);
    check(name, bus.data_out, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_issued(input string name, input int n, input int limit);
    int k = 0;
    while (issued.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(issued.size()), 32'(n));
  endtask

  function automatic logic [31:0] issued_at(input int i);
    return (issued.size() > i) ? issued[i] : 32'hDEAD_DEAD;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_words [4];

    vecs[0]  = '{1'b0, 1'b1, 32'h1000, 32'h0,  32'h0000_0002, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h1004, 32'h2,  32'h0,          1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h1000, 32'h0,  32'h0000_0012, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h1000, 32'h11, 32'h0,          1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000, 32'hEE, 32'h0,          1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h1000, 32'h22, 32'h0,          1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h1000, 32'h33, 32'h0,          1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h1000, 32'h44, 32'h0,          1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h1000, 32'h55, 32'h0,          1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h1000, 32'h0,  32'h0000_041C, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h1004, 32'h6,  32'h0,          1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'h1000, 32'h0,  32'h0000_0414, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'h1004, 32'h0,  32'h0,          1'b1};
    vecs[13] = '{1'b0, 1'b1, 32'h1008, 32'h0,  32'h54B6_789A, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 32'h100C, 32'h0,  32'h0,          1'b1};

    bus.io_we = 1'b0; bus.io_re = 1'b0; bus.mem_addr = '0; bus.data_in = '0;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_step_data", step_data, 32'h0);
    check("rst_new_data", {31'b0, step_new_data}, 32'h0);
    check("rst_cmd_full", {31'b0, bus.cmd_full}, 32'h0);
    rd_check("rst_status", 32'h1000, 32'h0000_0002);
    check("rst_no_strobe", 32'(issued.size()), 32'h0);

    // Single command: strobe two cycles after the count update, one cycle wide.
    wr(32'h1000, 32'h123);
    check("one_snd_c1", {31'b0, step_new_data}, 32'h0);
    idle(1);
    check("one_snd_c2", {31'b0, step_new_data}, 32'h0);
    idle(1);
    check("one_snd_c3", {31'b0, step_new_data}, 32'h1);
    check("one_data", step_data, 32'h123);
    idle(1);
    check("one_snd_c4", {31'b0, step_new_data}, 32'h0);
    idle(11);
    rd_check("one_busy_last", 32'h1000, 32'h0000_0003);
    rd_check("one_idle", 32'h1000, 32'h0000_0002);
    check("one_count", 32'(issued.size()), 32'h1);
    check("one_hold", step_data, 32'h123);

    // Paused fill, ignored out-of-window write, overflow, register reads.
    issued.delete();
    for (int i = 0; i < 15; i++) begin
      bus_cycle(vecs[i].we, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].rd) check($sformatf("vec%0d_rd", i), bus.data_out, vecs[i].exp_rd);
      check($sformatf("vec%0d_full", i), {31'b0, bus.cmd_full}, {31'b0, vecs[i].exp_full});
    end
    check("paused_no_strobe", 32'(issued.size()), 32'h0);
    wr(32'h1004, 32'h0);
    wait_issued("drain_cnt", 4, 300);
    idle(20);
    check("drain_total", 32'(issued.size()), 32'h4);
    exp_words = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) check($sformatf("drain_word%0d", i), issued_at(i), exp_words[i]);

    // Push while full in the ISSUE cycle: rejected despite the pop.
    issued.delete();
    wr(32'h1004, 32'h6);
    wr(32'h1000, 32'hA1);
    wr(32'h1000, 32'hA2);
    wr(32'h1000, 32'hA3);
    wr(32'h1000, 32'hA4);
    wr(32'h1004, 32'h0);
    idle(1);
    wr(32'h1000, 32'hA5);
    check("pf_cmd_full", {31'b0, bus.cmd_full}, 32'h0);
    rd_check("pf_status", 32'h1000, 32'h0000_0309);
    wait_issued("pf_cnt", 4, 300);
    idle(20);
    check("pf_total", 32'(issued.size()), 32'h4);
    exp_words = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    for (int i = 0; i < 4; i++) check($sformatf("pf_word%0d", i), issued_at(i), exp_words[i]);
    wr(32'h1004, 32'h4);
    rd_check("pf_ovf_clr", 32'h1000, 32'h0000_0002);

    // Stepper never acknowledges.
    issued.delete();
    never_busy = 1'b1;
    wr(32'h1000, 32'h77);
    idle(2);
    check("to_snd", {31'b0, step_new_data}, 32'h1);
    check("to_data", step_data, 32'h77);
    idle(15);
    rd_check("to_still_wait", 32'h1000, 32'h0000_0003);
`ifdef STEPPER_SCHED_TIMEOUT_EN
    rd_check("to_idle", 32'h1000, 32'h0000_0002);
    wr(32'h1000, 32'h78);
    wait_issued("to_next_cnt", 2, 20);
    check("to_next_word", issued_at(1), 32'h78);
`else
    rd_check("to_stuck", 32'h1000, 32'h0000_0003);
    wr(32'h1000, 32'h78);
    idle(30);
    check("to_no_next", 32'(issued.size()), 32'h1);
    rd_check("to_queued", 32'h1000, 32'h0000_0101);
`endif
    never_busy = 1'b0;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("to_rst_step_data", step_data, 32'h0);
    check("to_rst_data_out", bus.data_out, 32'h0);
    idle(20);

    // Flush during WAIT_DONE with three commands queued.
    issued.delete();
    wr(32'h1000, 32'hB1);
    wr(32'h1000, 32'hB2);
    wr(32'h1000, 32'hB3);
    wr(32'h1000, 32'hB4);
    rd_check("fl_before", 32'h1000, 32'h0000_0301);
    idle(2);
    wr(32'h1004, 32'h1);
    rd_check("fl_after", 32'h1000, 32'h0000_0003);
    idle(30);
    check("fl_strobes", 32'(issued.size()), 32'h1);
    check("fl_word", issued_at(0), 32'hB1);
    rd_check("fl_idle", 32'h1000, 32'h0000_0002);

    // Reset in WAIT_DONE.
    issued.delete();
    wr(32'h1000, 32'hC1);
    idle(6);
    rd_check("rm_wait_done", 32'h1000, 32'h0000_0003);
    reset = 1'b1;
    idle(1);
    check("rm_data_out", bus.data_out, 32'h0);
    check("rm_step_data", step_data, 32'h0);
    check("rm_new_data", {31'b0, step_new_data}, 32'h0);
    check("rm_cmd_full", {31'b0, bus.cmd_full}, 32'h0);
    reset = 1'b0;
    rd_check("rm_status", 32'h1000, 32'h0000_0002);
    check("rm_strobes", 32'(issued.size()), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
